mmio_arb: RTL and testbench



---
 rtl/mmio_arb_pkg.sv | 30 +++
 rtl/mmio_arb_rr.sv | 21 ++
 rtl/mmio_arb.sv | 172 +++++++++++++++++
 tb/tb_mmio_arb.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_arb_pkg.sv
// Shared types and widths for the two-master MMIO arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mmio_arb_pkg;

  // MMIO channel widths, identical to the soc request/response port.
  localparam int MMIO_ADDR_WIDTH = 32;
  localparam int MMIO_DATA_WIDTH = 32;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,  // arbitrate between masters
    ST_ISSUE = 2'b01,  // present held request to soc
    ST_WAIT  = 2'b10,  // accept soc response
    ST_RESP  = 2'b11   // present captured response to owner
  } arb_state_t;

  // One MMIO transaction as carried on either the request or response side.
  typedef struct packed {
    logic                       cmd;   // 0 = read, 1 = write
    logic [MMIO_ADDR_WIDTH-1:0] addr;
    logic [MMIO_DATA_WIDTH-1:0] data;
  } mmio_xact_t;

  // Index of the set bit in a one-hot 2-bit grant (bit 1 set -> master 1).
  function automatic logic gnt_to_idx(input logic [1:0] gnt);
    return gnt[1];
  endfunction

endpackage

// File: rtl/mmio_arb_rr.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the
// master that did not win last time. Purely combinational, zero latency.
// Backpressure: none; grant is only meaningful while the caller is idle.
// Ports: req[1:0] request vector, last_grant previous winner, gnt[1:0] one-hot.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mmio_arb.sv
// Two-master MMIO arbiter: round-robin grant, one transaction in flight,
// response steered back to the issuing master.
// Latency: accept -> s_req_val next cycle; s_resp -> mN_resp_val next cycle.
// Backpressure: s_req held indefinitely while s_req_rdy=0; response held
//   while owner's resp_rdy=0; no new grant until the RESP handshake.
// Ports: clk/rst_n; m0_*/m1_* master request+response; s_* soc request+
//   response; busy (state != IDLE); owner (master of current/last xact).
module mmio_arb
  import mmio_arb_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  // master 0
  input  logic                       m0_req_cmd,
  input  logic [MMIO_ADDR_WIDTH-1:0] m0_req_addr,
  input  logic [MMIO_DATA_WIDTH-1:0] m0_req_data,
  input  logic                       m0_req_val,
  output logic                       m0_req_rdy,
  output logic                       m0_resp_cmd,
  output logic [MMIO_ADDR_WIDTH-1:0] m0_resp_addr,
  output logic [MMIO_DATA_WIDTH-1:0] m0_resp_data,
  output logic                       m0_resp_val,
  input  logic                       m0_resp_rdy,
  // master 1
  input  logic                       m1_req_cmd,
  input  logic [MMIO_ADDR_WIDTH-1:0] m1_req_addr,
  input  logic [MMIO_DATA_WIDTH-1:0] m1_req_data,
  input  logic                       m1_req_val,
  output logic                       m1_req_rdy,
  output logic                       m1_resp_cmd,
  output logic [MMIO_ADDR_WIDTH-1:0] m1_resp_addr,
  output logic [MMIO_DATA_WIDTH-1:0] m1_resp_data,
  output logic                       m1_resp_val,
  input  logic                       m1_resp_rdy,
  // soc side
  output logic                       s_req_cmd,
  output logic [MMIO_ADDR_WIDTH-1:0] s_req_addr,
  output logic [MMIO_DATA_WIDTH-1:0] s_req_data,
  output logic                       s_req_val,
  input  logic                       s_req_rdy,
  input  logic                       s_resp_cmd,
  input  logic [MMIO_ADDR_WIDTH-1:0] s_resp_addr,
  input  logic [MMIO_DATA_WIDTH-1:0] s_resp_data,
  input  logic                       s_resp_val,
  output logic                       s_resp_rdy,
  // status
  output logic                       busy,
  output logic                       owner
);

  arb_state_t state;
  logic       last_grant;
  logic       owner_q;
  mmio_xact_t req_q;
  mmio_xact_t resp_q;

  // Registered handshake/status outputs, updated alongside the state.
  logic s_req_val_q;
  logic s_resp_rdy_q;
  logic busy_q;
  logic m0_resp_val_q;
  logic m1_resp_val_q;

  logic [1:0] req_vec;
  logic [1:0] gnt;
  logic       in_idle;
  logic       grant_fire;
  logic       owner_resp_rdy;
  mmio_xact_t m0_req;
  mmio_xact_t m1_req;
  mmio_xact_t s_resp;

  assign req_vec = {m1_req_val, m0_req_val};

  rr_arb2 u_rr (
    .req        (req_vec),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  // Grant is only offered in IDLE, so the non-owner sees rdy=0 elsewhere.
  assign in_idle    = (state == ST_IDLE);
  assign m0_req_rdy = in_idle & gnt[0];
  assign m1_req_rdy = in_idle & gnt[1];
  // gnt is non-zero only when the granted master is valid, so any grant fires.
  assign grant_fire = in_idle & (|gnt);

  assign m0_req = {m0_req_cmd, m0_req_addr, m0_req_data};
  assign m1_req = {m1_req_cmd, m1_req_addr, m1_req_data};
  assign s_resp = {s_resp_cmd, s_resp_addr, s_resp_data};

  assign owner_resp_rdy = owner_q ? m1_resp_rdy : m0_resp_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      last_grant    <= 1'b1;  // master 0 wins the first tie
      owner_q       <= 1'b0;
      req_q         <= '0;
      resp_q        <= '0;
      s_req_val_q   <= 1'b0;
      s_resp_rdy_q  <= 1'b0;
      busy_q        <= 1'b0;
      m0_resp_val_q <= 1'b0;
      m1_resp_val_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_fire) begin
            req_q       <= gnt[1] ? m1_req : m0_req;
            owner_q     <= gnt_to_idx(gnt);
            last_grant  <= gnt_to_idx(gnt);
            s_req_val_q <= 1'b1;
            busy_q      <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Request stays parked in req_q for as long as soc stalls.
          if (s_req_rdy) begin
            s_req_val_q  <= 1'b0;
            s_resp_rdy_q <= 1'b1;
            state        <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (s_resp_val) begin
            resp_q        <= s_resp;
            s_resp_rdy_q  <= 1'b0;
            m0_resp_val_q <= ~owner_q;
            m1_resp_val_q <= owner_q;
            state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (owner_resp_rdy) begin
            m0_resp_val_q <= 1'b0;
            m1_resp_val_q <= 1'b0;
            busy_q        <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // soc request side: straight from the holding register.
  assign s_req_val  = s_req_val_q;
  assign s_req_cmd  = req_q.cmd;
  assign s_req_addr = req_q.addr;
  assign s_req_data = req_q.data;
  assign s_resp_rdy = s_resp_rdy_q;

  // Response fields are only shown to the master whose valid is up, so the
  // other master never sees a stale transaction on its response bus.
  assign m0_resp_val  = m0_resp_val_q;
  assign m0_resp_cmd  = m0_resp_val_q & resp_q.cmd;
  assign m0_resp_addr = m0_resp_val_q ? resp_q.addr : '0;
  assign m0_resp_data = m0_resp_val_q ? resp_q.data : '0;

  assign m1_resp_val  = m1_resp_val_q;
  assign m1_resp_cmd  = m1_resp_val_q & resp_q.cmd;
  assign m1_resp_addr = m1_resp_val_q ? resp_q.addr : '0;
  assign m1_resp_data = m1_resp_val_q ? resp_q.data : '0;

  assign busy  = busy_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_mmio_arb.sv
module tb_mmio_arb;
  import mmio_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                       m0_req_cmd, m0_req_val, m0_req_rdy;
  logic [MMIO_ADDR_WIDTH-1:0] m0_req_addr;
  logic [MMIO_DATA_WIDTH-1:0] m0_req_data;
  logic                       m0_resp_cmd, m0_resp_val, m0_resp_rdy;
  logic [MMIO_ADDR_WIDTH-1:0] m0_resp_addr;
  logic [MMIO_DATA_WIDTH-1:0] m0_resp_data;
  logic                       m1_req_cmd, m1_req_val, m1_req_rdy;
  logic [MMIO_ADDR_WIDTH-1:0] m1_req_addr;
  logic [MMIO_DATA_WIDTH-1:0] m1_req_data;
  logic                       m1_resp_cmd, m1_resp_val, m1_resp_rdy;
  logic [MMIO_ADDR_WIDTH-1:0] m1_resp_addr;
  logic [MMIO_DATA_WIDTH-1:0] m1_resp_data;
  logic                       s_req_cmd, s_req_val, s_req_rdy;
  logic [MMIO_ADDR_WIDTH-1:0] s_req_addr;
  logic [MMIO_DATA_WIDTH-1:0] s_req_data;
  logic                       s_resp_cmd, s_resp_val, s_resp_rdy;
  logic [MMIO_ADDR_WIDTH-1:0] s_resp_addr;
  logic [MMIO_DATA_WIDTH-1:0] s_resp_data;
  logic                       busy, owner;

  mmio_arb dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_cmd(m0_req_cmd), .m0_req_addr(m0_req_addr), .m0_req_data(m0_req_data),
    .m0_req_val(m0_req_val), .m0_req_rdy(m0_req_rdy),
    .m0_resp_cmd(m0_resp_cmd), .m0_resp_addr(m0_resp_addr), .m0_resp_data(m0_resp_data),
    .m0_resp_val(m0_resp_val), .m0_resp_rdy(m0_resp_rdy),
    .m1_req_cmd(m1_req_cmd), .m1_req_addr(m1_req_addr), .m1_req_data(m1_req_data),
    .m1_req_val(m1_req_val), .m1_req_rdy(m1_req_rdy),
    .m1_resp_cmd(m1_resp_cmd), .m1_resp_addr(m1_resp_addr), .m1_resp_data(m1_resp_data),
    .m1_resp_val(m1_resp_val), .m1_resp_rdy(m1_resp_rdy),
    .s_req_cmd(s_req_cmd), .s_req_addr(s_req_addr), .s_req_data(s_req_data),
    .s_req_val(s_req_val), .s_req_rdy(s_req_rdy),
    .s_resp_cmd(s_resp_cmd), .s_resp_addr(s_resp_addr), .s_resp_data(s_resp_data),
    .s_resp_val(s_resp_val), .s_resp_rdy(s_resp_rdy),
    .busy(busy), .owner(owner)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard queues: expected soc requests in grant order, and expected
  // responses per master.
  mmio_xact_t exp_sreq[$];
  mmio_xact_t exp_r0[$];
  mmio_xact_t exp_r1[$];

  function automatic mmio_xact_t mk(input logic c, input logic [31:0] a, input logic [31:0] d);
    return {c, a, d};
  endfunction

  task automatic chk(input string name, input logic [131:0] act, input logic [131:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops and compares whenever a handshake is visible.
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_req_val && s_req_rdy) begin
        chk("sreq_expected", exp_sreq.size() != 0, 1);
        if (exp_sreq.size() != 0)
          chk("sreq", {s_req_cmd, s_req_addr, s_req_data}, exp_sreq.pop_front());
      end
      if (m0_resp_val && m0_resp_rdy) begin
        chk("m0_resp_expected", exp_r0.size() != 0, 1);
        if (exp_r0.size() != 0)
          chk("m0_resp", {m0_resp_cmd, m0_resp_addr, m0_resp_data}, exp_r0.pop_front());
      end
      if (m1_resp_val && m1_resp_rdy) begin
        chk("m1_resp_expected", exp_r1.size() != 0, 1);
        if (exp_r1.size() != 0)
          chk("m1_resp", {m1_resp_cmd, m1_resp_addr, m1_resp_data}, exp_r1.pop_front());
      end
      if (m0_resp_val && m1_resp_val)
        chk("resp_onehot", {m0_resp_val, m1_resp_val}, 2'b00);
    end
  end

  task automatic chk_reset_outs(input string name);
    chk({name, "_ctl"}, {busy, owner, s_req_val, s_resp_rdy,
                         m0_req_rdy, m1_req_rdy, m0_resp_val, m1_resp_val}, 0);
    chk({name, "_sreq"}, {s_req_cmd, s_req_addr, s_req_data}, 0);
    chk({name, "_mresp"}, {m0_resp_cmd, m0_resp_addr, m0_resp_data,
                           m1_resp_cmd, m1_resp_addr, m1_resp_data}, 0);
  endtask

  // Present a request on master m and wait for acceptance; keep=1 leaves
  // val asserted so the next call can follow back-to-back.
  task automatic m_issue(input bit m, input logic cmd, input logic [31:0] addr,
                         input logic [31:0] data, input bit keep);
    bit done = 0;
    if (!m) begin
      m0_req_cmd = cmd; m0_req_addr = addr; m0_req_data = data; m0_req_val = 1'b1;
    end else begin
      m1_req_cmd = cmd; m1_req_addr = addr; m1_req_data = data; m1_req_val = 1'b1;
    end
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      done = m ? m1_req_rdy : m0_req_rdy;
    end
    chk(m ? "m1_accept" : "m0_accept", done, 1);
    if (done) begin
      @(posedge clk); #1;
    end
    if (!keep) begin
      if (!m) m0_req_val = 1'b0;
      else    m1_req_val = 1'b0;
    end
  endtask

  // soc model for one transaction: stall, accept, respond after lat cycles.
  task automatic soc_serve(input int stall, input int lat, input logic [31:0] rdata);
    bit seen = 0;
    bit ok = 1;
    mmio_xact_t first;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = s_req_val;
    end
    chk("soc_req_seen", seen, 1);
    first = {s_req_cmd, s_req_addr, s_req_data};
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if ({s_req_cmd, s_req_addr, s_req_data} !== first || !s_req_val ||
          m0_req_rdy || m1_req_rdy || !busy)
        ok = 0;
    end
    if (stall > 0) chk("stall_hold", ok, 1);
    @(posedge clk); #1 s_req_rdy = 1'b1;
    @(posedge clk); #1 s_req_rdy = 1'b0;
    chk("issue_to_wait", {s_req_val, s_resp_rdy}, 2'b01);
    repeat (lat) @(posedge clk);
    #1;
    s_resp_cmd  = first.cmd;
    s_resp_addr = first.addr;
    s_resp_data = first.cmd ? first.data : rdata;
    s_resp_val  = 1'b1;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = s_resp_rdy;
    end
    chk("soc_resp_taken", seen, 1);
    @(posedge clk); #1 s_resp_val = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = (exp_sreq.size() == 0) && (exp_r0.size() == 0) &&
             (exp_r1.size() == 0) && !busy;
    end
    chk({name, "_drain"}, done, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #3 rst_n = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit ok;
    mmio_xact_t held;
    m0_req_cmd = 0; m0_req_addr = 0; m0_req_data = 0; m0_req_val = 0; m0_resp_rdy = 1;
    m1_req_cmd = 0; m1_req_addr = 0; m1_req_data = 0; m1_req_val = 0; m1_resp_rdy = 1;
    s_req_rdy = 0; s_resp_cmd = 0; s_resp_addr = 0; s_resp_data = 0; s_resp_val = 0;

    repeat (2) @(negedge clk);
    chk_reset_outs("reset");
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: lone m0 read
    exp_sreq.push_back(mk(0, 32'h8000_0010, 32'h0));
    exp_r0.push_back(mk(0, 32'h8000_0010, 32'hDEAD_BEEF));
    m_issue(0, 0, 32'h8000_0010, 32'h0, 0);
    @(negedge clk);
    chk("t1_issue_next_cycle", {s_req_val, busy, owner}, 3'b110);
    soc_serve(0, 1, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t1_resp_steer", {m0_resp_val, m1_resp_val}, 2'b10);
    drain("t1");

    // 2: tie right after reset, both held valid for 4 transactions
    do_reset();
    exp_sreq.push_back(mk(0, 32'h1000_0000, 0));
    exp_sreq.push_back(mk(0, 32'h2000_0000, 0));
    exp_sreq.push_back(mk(0, 32'h1000_0004, 0));
    exp_sreq.push_back(mk(0, 32'h2000_0004, 0));
    exp_r0.push_back(mk(0, 32'h1000_0000, 32'h1111_1111));
    exp_r1.push_back(mk(0, 32'h2000_0000, 32'h2222_2222));
    exp_r0.push_back(mk(0, 32'h1000_0004, 32'h3333_3333));
    exp_r1.push_back(mk(0, 32'h2000_0004, 32'h4444_4444));
    fork
      begin
        m_issue(0, 0, 32'h1000_0000, 0, 1);
        m_issue(0, 0, 32'h1000_0004, 0, 0);
      end
      begin
        m_issue(1, 0, 32'h2000_0000, 0, 1);
        m_issue(1, 0, 32'h2000_0004, 0, 0);
      end
      begin
        soc_serve(0, 1, 32'h1111_1111);
        soc_serve(0, 1, 32'h2222_2222);
        soc_serve(0, 1, 32'h3333_3333);
        soc_serve(0, 1, 32'h4444_4444);
      end
    join
    drain("t2");

    // 3: m1 write with 50-cycle soc stall, then m1 holds off its response
    m1_resp_rdy = 1'b0;
    exp_sreq.push_back(mk(1, 32'h0000_0004, 32'hCAFE_F00D));
    exp_r1.push_back(mk(1, 32'h0000_0004, 32'hCAFE_F00D));
    exp_sreq.push_back(mk(0, 32'h8000_0020, 0));
    exp_r0.push_back(mk(0, 32'h8000_0020, 32'h5555_AAAA));
    m_issue(1, 1, 32'h0000_0004, 32'hCAFE_F00D, 0);
    m0_req_cmd = 0; m0_req_addr = 32'h8000_0020; m0_req_data = 0; m0_req_val = 1'b1;
    soc_serve(50, 1, 32'h0);
    @(negedge clk);
    held = {m1_resp_cmd, m1_resp_addr, m1_resp_data};
    chk("t3_resp_fields", held, mk(1, 32'h0000_0004, 32'hCAFE_F00D));
    ok = 1;
    repeat (10) begin
      @(negedge clk);
      if ({m1_resp_cmd, m1_resp_addr, m1_resp_data} !== held || !m1_resp_val ||
          s_resp_rdy || !busy || m0_req_rdy || m0_resp_val)
        ok = 0;
    end
    chk("t3_resp_hold", ok, 1);
    @(posedge clk); #1 m1_resp_rdy = 1'b1;
    m_issue(0, 0, 32'h8000_0020, 0, 0);
    soc_serve(0, 2, 32'h5555_AAAA);
    drain("t3");

    // 4: reset during WAIT, spurious response in IDLE, then a tie
    exp_sreq.push_back(mk(1, 32'h9000_0000, 32'h0BAD_F00D));
    m_issue(0, 1, 32'h9000_0000, 32'h0BAD_F00D, 0);
    @(negedge clk);
    @(posedge clk); #1 s_req_rdy = 1'b1;
    @(posedge clk); #1 s_req_rdy = 1'b0;
    chk("t4_in_wait", {busy, s_resp_rdy, owner}, 3'b110);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("t4_async_reset");
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    s_resp_cmd = 1; s_resp_addr = 32'h9000_0000; s_resp_data = 32'h0BAD_F00D; s_resp_val = 1'b1;
    ok = 1;
    repeat (3) begin
      @(negedge clk);
      if (m0_resp_val || m1_resp_val || s_resp_rdy || busy) ok = 0;
    end
    chk("t4_spurious_ignored", ok, 1);
    @(posedge clk); #1 s_resp_val = 1'b0;
    exp_sreq.push_back(mk(0, 32'h3000_0000, 0));
    exp_sreq.push_back(mk(0, 32'h3000_0100, 0));
    exp_r0.push_back(mk(0, 32'h3000_0000, 32'h0000_3000));
    exp_r1.push_back(mk(0, 32'h3000_0100, 32'h0000_3100));
    fork
      m_issue(0, 0, 32'h3000_0000, 0, 0);
      m_issue(1, 0, 32'h3000_0100, 0, 0);
      begin
        soc_serve(0, 1, 32'h0000_3000);
        soc_serve(0, 1, 32'h0000_3100);
      end
    join
    drain("t4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
